// File: rtl/corner_turn_buffer.sv
// Corner-turn buffer: stores one CPI in fast-time (pulse-major) order and
// re-emits it in slow-time order, one contiguous pulse vector per range gate.
module corner_turn_buffer #(
  parameter int unsigned DATA_WIDTH      = 16,
  parameter int unsigned NUM_PULSES      = 64,
  parameter int unsigned NUM_RANGE_GATES = 256
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               enable,
  input  logic [DATA_WIDTH-1:0]              data_in,
  input  logic                               data_valid,
  output logic                               data_ready,
  output logic [DATA_WIDTH-1:0]              data_out,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic                               out_last,
  output logic [$clog2(NUM_RANGE_GATES)-1:0] gate_index,
  output logic                               frame_done
);

  localparam int unsigned PW    = $clog2(NUM_PULSES);
  localparam int unsigned GW    = $clog2(NUM_RANGE_GATES);
  localparam int unsigned DEPTH = NUM_PULSES * NUM_RANGE_GATES;

  typedef enum logic {FILL, DRAIN} state_t;

  state_t                state;
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [GW-1:0]         wr_g, rd_g;
  logic [PW-1:0]         wr_p, rd_p;
  logic                  rd_active;
  logic                  out_frame_last;
  logic                  skid_valid, skid_last, skid_frame_last;
  logic [DATA_WIDTH-1:0] skid_data;
  logic [GW-1:0]         skid_gate;

  logic                  in_xfer, out_xfer, out_free, rd_issue;
  logic                  wr_last, rd_last_pulse, rd_frame_last;
  logic [DATA_WIDTH-1:0] rd_data;

  assign data_ready    = rst_n & enable & (state == FILL);
  assign in_xfer       = data_valid & data_ready;
  assign out_xfer      = out_valid & out_ready;
  assign out_free      = ~out_valid | out_ready;
  assign frame_done    = rst_n & out_xfer & out_frame_last;
  assign wr_last       = (wr_p == PW'(NUM_PULSES - 1)) && (wr_g == GW'(NUM_RANGE_GATES - 1));
  assign rd_last_pulse = (rd_p == PW'(NUM_PULSES - 1));
  assign rd_frame_last = rd_last_pulse && (rd_g == GW'(NUM_RANGE_GATES - 1));
  assign rd_data       = mem[{rd_p, rd_g}];

  // A read is only issued when its result has a guaranteed landing slot
  // (output register or skid) at the next edge.
  assign rd_issue = (state == DRAIN) & rd_active & ~(out_valid & skid_valid & ~out_ready);

  // Sample store, written pulse-major
  always_ff @(posedge clk) begin
    if (in_xfer) mem[{wr_p, wr_g}] <= data_in;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state           <= FILL;
      wr_g            <= '0;
      wr_p            <= '0;
      rd_g            <= '0;
      rd_p            <= '0;
      rd_active       <= 1'b0;
      out_valid       <= 1'b0;
      data_out        <= '0;
      out_last        <= 1'b0;
      gate_index      <= '0;
      out_frame_last  <= 1'b0;
      skid_valid      <= 1'b0;
      skid_data       <= '0;
      skid_last       <= 1'b0;
      skid_gate       <= '0;
      skid_frame_last <= 1'b0;
    end else begin
      case (state)
        FILL: begin
          if (in_xfer) begin
            wr_g <= wr_g + GW'(1);
            if (wr_g == GW'(NUM_RANGE_GATES - 1)) wr_p <= wr_p + PW'(1);
            if (wr_last) begin
              state     <= DRAIN;
              rd_active <= 1'b1;
            end
          end
        end
        DRAIN: begin
          if (rd_issue) begin
            rd_p <= rd_p + PW'(1);
            if (rd_last_pulse) rd_g <= rd_g + GW'(1);
            if (rd_frame_last) rd_active <= 1'b0;
          end
          // Output register refills from skid first, then from the memory read
          if (out_free) begin
            if (skid_valid) begin
              data_out       <= skid_data;
              out_last       <= skid_last;
              gate_index     <= skid_gate;
              out_frame_last <= skid_frame_last;
              skid_valid     <= rd_issue;
              if (rd_issue) begin
                skid_data       <= rd_data;
                skid_last       <= rd_last_pulse;
                skid_gate       <= rd_g;
                skid_frame_last <= rd_frame_last;
              end
            end else begin
              out_valid <= rd_issue;
              if (rd_issue) begin
                data_out       <= rd_data;
                out_last       <= rd_last_pulse;
                gate_index     <= rd_g;
                out_frame_last <= rd_frame_last;
              end
            end
          end else if (rd_issue) begin
            skid_valid      <= 1'b1;
            skid_data       <= rd_data;
            skid_last       <= rd_last_pulse;
            skid_gate       <= rd_g;
            skid_frame_last <= rd_frame_last;
          end
          if (out_xfer && out_frame_last) state <= FILL;
        end
        default: state <= FILL;
      endcase
    end
  end

endmodule

// File: tb/tb_corner_turn_buffer.sv
// Self-checking bench for corner_turn_buffer: small 4x8 instance against a
// queue-based corner-turn model, plus a default-size ramp smoke run.
module tb_corner_turn_buffer;

  localparam int DW = 16;
  localparam int NP = 4;
  localparam int NG = 8;
  localparam int NT = NP * NG;
  localparam int DP = 64;
  localparam int DG = 256;
  localparam int DT = DP * DG;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n, enable, data_valid, out_ready;
  logic [DW-1:0] data_in, data_out;
  logic          data_ready, out_valid, out_last, frame_done;
  logic [2:0]    gate_index;

  logic          d_enable, d_data_valid, d_out_ready;
  logic [DW-1:0] d_data_in, d_data_out;
  logic          d_data_ready, d_out_valid, d_out_last, d_frame_done;
  logic [7:0]    d_gate_index;

  corner_turn_buffer #(.DATA_WIDTH(DW), .NUM_PULSES(NP), .NUM_RANGE_GATES(NG)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .data_in(data_in),
    .data_valid(data_valid), .data_ready(data_ready), .data_out(data_out),
    .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
    .gate_index(gate_index), .frame_done(frame_done)
  );

  corner_turn_buffer dut_def (
    .clk(clk), .rst_n(rst_n), .enable(d_enable), .data_in(d_data_in),
    .data_valid(d_data_valid), .data_ready(d_data_ready), .data_out(d_data_out),
    .out_valid(d_out_valid), .out_ready(d_out_ready), .out_last(d_out_last),
    .gate_index(d_gate_index), .frame_done(d_frame_done)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [DW-1:0] d;
    logic          last;
    logic [2:0]    g;
    logic          fd;
  } exp_t;

  logic [DW-1:0] acc[$];
  exp_t          expq[$];
  logic [DW-1:0] out_log[$];
  bit            model_fill = 1'b1;
  bit            first_pending = 1'b0;
  bit            full_rate = 1'b0;
  bit            prev_stall = 1'b0;
  logic [DW-1:0] prev_d;
  logic          prev_last;
  logic [2:0]    prev_g;
  int            cyc = 0;
  int            last_in_cyc = 0;
  int            out_cnt = 0;
  int            fd_cnt = 0;
  int            d_cnt = 0;
  int            d_fd_cnt = 0;
  int            d_last_cnt = 0;

  always @(posedge clk) cyc++;

  // Single compare process for both instances
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      chk("ready_in_reset", data_ready, 0);
      acc.delete();
      expq.delete();
      model_fill    = 1'b1;
      first_pending = 1'b0;
      prev_stall    = 1'b0;
    end else begin
      chk("data_ready", data_ready, enable & model_fill);
      if (prev_stall) begin
        chk("stall_valid", out_valid, 1);
        chk("stall_data", data_out, prev_d);
        chk("stall_last", out_last, prev_last);
        chk("stall_gate", gate_index, prev_g);
      end
      if (model_fill) chk("idle_valid", out_valid, 0);
      if (first_pending && cyc == last_in_cyc + 1) chk("early_valid", out_valid, 0);
      if (first_pending && cyc == last_in_cyc + 2) begin
        chk("first_latency", out_valid, 1);
        first_pending = 1'b0;
      end
      if (full_rate && !model_fill && expq.size() > 0 && cyc >= last_in_cyc + 2)
        chk("no_bubble", out_valid, 1);
      if (out_valid && out_ready) begin
        if (expq.size() == 0) begin
          chk("extra_output", 1, 0);
        end else begin
          e = expq.pop_front();
          chk("data_out", data_out, e.d);
          chk("out_last", out_last, e.last);
          chk("gate_index", gate_index, e.g);
          chk("frame_done", frame_done, e.fd);
          out_log.push_back(data_out);
          out_cnt++;
          if (frame_done) fd_cnt++;
          if (expq.size() == 0) model_fill = 1'b1;
        end
      end else begin
        chk("frame_done_idle", frame_done, 0);
      end
      prev_stall = out_valid && !out_ready;
      prev_d     = data_out;
      prev_last  = out_last;
      prev_g     = gate_index;
      if (data_valid && data_ready) begin
        acc.push_back(data_in);
        if (acc.size() == NT) begin
          for (int g = 0; g < NG; g++)
            for (int p = 0; p < NP; p++) begin
              e.d    = acc[p * NG + g];
              e.last = (p == NP - 1);
              e.g    = 3'(g);
              e.fd   = (g == NG - 1) && (p == NP - 1);
              expq.push_back(e);
            end
          acc.delete();
          model_fill    = 1'b0;
          first_pending = 1'b1;
          last_in_cyc   = cyc;
        end
      end

      if (d_out_valid && d_out_ready) begin
        chk("d_data_out", d_data_out, 32'((d_cnt % DP) * DG + d_cnt / DP));
        chk("d_out_last", d_out_last, (d_cnt % DP) == DP - 1);
        chk("d_gate_index", d_gate_index, 32'(d_cnt / DP));
        chk("d_frame_done", d_frame_done, d_cnt == DT - 1);
        if (d_out_last) d_last_cnt++;
        if (d_frame_done) d_fd_cnt++;
        d_cnt++;
      end
    end
  end

  // Streams n samples valued base + p*16 + g, with random enable/valid stalls
  task automatic feed(input int base, input int stall_pct, input int n);
    int sent;
    int guard;
    sent  = 0;
    guard = 0;
    while (sent < n && guard < 5000) begin
      @(posedge clk); #1;
      enable     = ($urandom_range(99) >= stall_pct);
      data_valid = ($urandom_range(99) >= stall_pct);
      data_in    = DW'(base + (sent / NG) * 16 + (sent % NG));
      @(negedge clk);
      if (data_valid && data_ready) sent++;
      guard++;
    end
    if (guard >= 5000) chk("feed_timeout", 0, 1);
    @(posedge clk); #1;
    data_valid = 1'b0;
  endtask

  task automatic drain(input int n, input int ready_pct, input bit hold);
    int start;
    int guard;
    start = out_cnt;
    guard = 0;
    while (out_cnt < start + n && guard < 3000) begin
      @(posedge clk); #1;
      out_ready = ($urandom_range(99) < ready_pct);
      if (hold) begin
        data_valid = 1'b1;
        data_in    = 16'hFFFF;
        enable     = 1'($urandom_range(1));
      end
      @(negedge clk); #1;
      guard++;
    end
    if (guard >= 3000) chk("drain_timeout", 0, 1);
    if (hold) data_valid = 1'b0;
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_out_last"}, out_last, 0);
    chk({tag, "_data_out"}, data_out, 0);
    chk({tag, "_gate_index"}, gate_index, 0);
    chk({tag, "_frame_done"}, frame_done, 0);
    chk({tag, "_data_ready"}, data_ready, 0);
  endtask

  task automatic do_reset(input string tag);
    @(posedge clk); #1;
    rst_n      = 1'b0;
    enable     = 1'b0;
    data_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check_reset_vals(tag);
  endtask

  initial begin
    int fd0;
    int guard;
    rst_n = 1'b0; enable = 1'b0; data_valid = 1'b0; data_in = '0; out_ready = 1'b0;
    d_enable = 1'b0; d_data_valid = 1'b0; d_data_in = '0; d_out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check_reset_vals("por");

    // Basic order at full rate, with literal pins on the sequence
    out_ready = 1'b1;
    full_rate = 1'b1;
    out_log.delete();
    fd0 = fd_cnt;
    feed(0, 0, NT);
    drain(NT, 100, 0);
    full_rate = 1'b0;
    chk("basic_count", out_log.size(), NT);
    if (out_log.size() == NT) begin
      chk("basic_pin0", out_log[0], 16'h00);
      chk("basic_pin1", out_log[1], 16'h10);
      chk("basic_pin3", out_log[3], 16'h30);
      chk("basic_pin4", out_log[4], 16'h01);
      chk("basic_pin31", out_log[31], 16'h37);
    end
    chk("basic_fd_once", fd_cnt - fd0, 1);

    // Backpressure
    fd0 = fd_cnt;
    feed(0, 0, NT);
    drain(NT, 50, 0);
    chk("bp_fd_once", fd_cnt - fd0, 1);

    // Input stalls
    feed(0, 50, NT);
    drain(NT, 100, 0);

    // Fill lockout then offset second frame
    feed(0, 0, NT);
    drain(NT, 60, 1);
    out_log.delete();
    feed(256, 30, NT);
    drain(NT, 70, 0);
    if (out_log.size() == NT) chk("lock_pin_last", out_log[NT - 1], 16'h137);
    else chk("lock_count", out_log.size(), NT);

    // Reset mid-fill and mid-drain, then a clean frame
    enable = 1'b1;
    feed(0, 0, 10);
    do_reset("rst_fill");
    feed(0, 0, NT);
    drain(5, 100, 0);
    do_reset("rst_drain");
    out_log.delete();
    feed(0, 20, NT);
    drain(NT, 100, 0);
    chk("post_rst_count", out_log.size(), NT);
    if (out_log.size() == NT)
      for (int k = 0; k < NT; k++)
        chk("post_rst_seq", out_log[k], 32'(((k % NP) << 4) | (k / NP)));

    // Default-size ramp smoke
    d_enable    = 1'b1;
    d_out_ready = 1'b1;
    for (int i = 0; i < DT; i++) begin
      @(posedge clk); #1;
      d_data_valid = 1'b1;
      d_data_in    = DW'(i);
      @(negedge clk);
      if (!d_data_ready) chk("d_ready", d_data_ready, 1);
    end
    @(posedge clk); #1;
    d_data_valid = 1'b0;
    guard = 0;
    while (d_cnt < DT && guard < 20000) begin
      @(negedge clk); #1;
      guard++;
    end
    chk("d_total", d_cnt, DT);
    chk("d_fd_once", d_fd_cnt, 1);
    chk("d_last_count", d_last_cnt, DG);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/corner_turn_buffer.md
Name: corner_turn_buffer

Overview:
- Upstream neighbour of the Doppler stage.
- Collects range-compressed samples in fast-time order: pulse-major, one pulse of NUM_RANGE_GATES samples after another.
- Once a full CPI of NUM_PULSES pulses is stored, re-emits the data in slow-time order: for each range gate, all NUM_PULSES samples. The Doppler stage therefore receives one contiguous pulse vector per range gate.
- Single on-chip buffer; strictly alternating fill and drain phases.

Parameters:
- DATA_WIDTH, 16, sample width in bits.
- NUM_PULSES, 64, pulses per CPI; matches the Doppler FFT length; power of two, ≥2.
- NUM_RANGE_GATES, 256, range gates per pulse; power of two, ≥2.

Ports:
- clk  in  1  single clock; all logic on rising edge.
- rst_n  in  1  reset; synchronous, active-low.
- enable  in  1  permits acceptance of new input in FILL.
- data_in  in  DATA_WIDTH  input sample, fast-time order.
- data_valid  in  1  data_in valid.
- data_ready  out  1  buffer accepts data_in this cycle.
- data_out  out  DATA_WIDTH  output sample, slow-time order.
- out_valid  out  1  data_out valid.
- out_ready  in  1  downstream accepts data_out.
- out_last  out  1  marks pulse index NUM_PULSES-1 of current range gate.
- gate_index  out  clog2(NUM_RANGE_GATES)  range gate of current data_out.
- frame_done  out  1  one-cycle pulse on final drain transfer.

Behaviour:
- Reset (rst_n low at clk edge):
  - state=FILL; all counters 0.
  - data_ready=0, out_valid=0, out_last=0, frame_done=0, data_out=0, gate_index=0.
  - Memory contents not cleared.
  - Reset mid-FILL or mid-DRAIN abandons the frame; the next accepted sample is pulse 0 gate 0.
- Handshakes:
  - Input transfer = data_valid & data_ready.
  - Output transfer = out_valid & out_ready.
  - While out_valid=1 and out_ready=0: data_out, out_last and gate_index hold stable. No sample is lost or duplicated.
- FILL:
  - data_ready = enable (registered or combinational, but never high outside FILL or during reset).
  - Each input transfer writes mem[p*NUM_RANGE_GATES+g]. Counter g increments; on wrap, p increments.
  - enable=0 stalls acceptance; counters hold.
  - The transfer with p=NUM_PULSES-1, g=NUM_RANGE_GATES-1 moves to DRAIN next cycle. data_ready is 0 from that cycle on.
- DRAIN:
  - Read order: gate g outer (0..NUM_RANGE_GATES-1), pulse p inner (0..NUM_PULSES-1), address p*NUM_RANGE_GATES+g.
  - Memory has a synchronous 1-cycle read.
  - First out_valid is asserted exactly 2 cycles after the final FILL input transfer.
  - With out_ready held high, one output transfer per cycle with no bubbles; total drain = NUM_PULSES*NUM_RANGE_GATES cycles.
  - The read pipeline (prefetch plus holding/skid register) must sustain full throughput under arbitrary out_ready toggling.
  - out_last=1 for p=NUM_PULSES-1; gate_index=g of the presented sample.
  - enable has no effect in DRAIN; the drain always completes.
  - On the transfer of the last sample (g=NUM_RANGE_GATES-1, p=NUM_PULSES-1), frame_done=1 for exactly one cycle.
  - The next cycle returns to FILL with counters 0; data_ready may rise that cycle.
- Widths: counters sized clog2 of their ranges, wrap naturally. Address = {p,g} concatenation (power-of-two sizes). Data passes unmodified, no arithmetic.
- Simultaneous events: data_valid high in DRAIN is ignored (no write, no counter change). Reset has priority over all.

Test Plan:
Bench uses NUM_PULSES=4, NUM_RANGE_GATES=8, data_in = p*16+g, unless noted.
- Basic order: stream 32 samples back-to-back, out_ready=1 -> outputs 0x00,0x10,0x20,0x30,0x01,0x11,…,0x37. out_last on every 4th output. gate_index 0..7. frame_done with 0x37. First out_valid 2 cycles after last input.
- Backpressure: drive out_ready with a pseudo-random 50% pattern -> identical 32-value sequence. data_out stable while stalled. No duplicates or drops. frame_done exactly once.
- Input stalls: toggle enable and data_valid randomly during FILL -> only handshaken samples are stored. Output order is unchanged. data_ready=0 whenever enable=0.
- Fill lockout: hold data_valid=1 throughout DRAIN with data_in=0xFFFF -> no corruption of outputs. data_ready=0 until the cycle after frame_done. Second frame (data_in offset +0x100) drains correctly.
- Reset mid-operation: assert rst_n=0 for 1 cycle after 10 inputs, then after 5 drain outputs -> all outputs at reset values. A subsequent full frame drains exactly 0x00…0x37 with no stale data.
- Default params smoke: 64×256 ramp -> 16384 outputs in slow-time order. out_last on every 64th output. frame_done on output 16384.
